// File: rtl/branch_outcome_tracker_pkg.sv
// Shared definitions for the branch outcome tracker.
// Holds the default geometry of the tracker (queue depth, predictor index
// width, PC width) and the {predicted, actual} encoding reported to the
// predictor on every resolution.
package branch_outcome_tracker_pkg;

   localparam int BOT_DEPTH = 4;
   localparam int BOT_IDX_W = 4;
   localparam int BOT_PC_W  = 16;

   // {predicted, actual} as seen by the predictor update port.
   typedef enum logic [1:0] {
      PA_CORRECT_NT   = 2'b00,
      PA_MISSED_TAKEN = 2'b01,
      PA_MISSED_NT    = 2'b10,
      PA_CORRECT_T    = 2'b11
   } pred_actual_e;

   function automatic pred_actual_e pack_pred_actual(input logic pred, input logic actual);
      return pred_actual_e'({pred, actual});
   endfunction

   function automatic logic is_mispredict(input logic pred, input logic actual);
      return pred != actual;
   endfunction

endpackage

// File: rtl/bot_entry_fifo.sv
// In-order storage for in-flight predicted branches.
// Entries are written at the tail in program order and read from the head.
// A flush empties the queue in one cycle; storage contents are not cleared.
// Ports:
//   Clock, Reset       rising-edge clock, synchronous active-high reset
//   push_en            write {push_idx, push_pred, push_alt_pc} at the tail
//   pop_en             retire the head entry
//   flush_en           discard every entry (wins over push/pop)
//   head_*             fields of the oldest entry
//   count              number of occupied entries
module bot_entry_fifo
   import branch_outcome_tracker_pkg::*;
#(
   parameter int DEPTH = BOT_DEPTH,
   parameter int IDX_W = BOT_IDX_W,
   parameter int PC_W  = BOT_PC_W
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     push_en,
   input  logic                     pop_en,
   input  logic                     flush_en,
   input  logic [IDX_W-1:0]         push_idx,
   input  logic                     push_pred,
   input  logic [PC_W-1:0]          push_alt_pc,
   output logic [IDX_W-1:0]         head_idx,
   output logic                     head_pred,
   output logic [PC_W-1:0]          head_alt_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [IDX_W-1:0] idx_mem_q  [DEPTH];
   logic [IDX_W-1:0] idx_mem_d  [DEPTH];
   logic             pred_mem_q [DEPTH];
   logic             pred_mem_d [DEPTH];
   logic [PC_W-1:0]  alt_mem_q  [DEPTH];
   logic [PC_W-1:0]  alt_mem_d  [DEPTH];

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      idx_mem_d  = idx_mem_q;
      pred_mem_d = pred_mem_q;
      alt_mem_d  = alt_mem_q;
      if (flush_en) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_en) begin
            idx_mem_d[wr_ptr_q]  = push_idx;
            pred_mem_d[wr_ptr_q] = push_pred;
            alt_mem_d[wr_ptr_q]  = push_alt_pc;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
         end
         if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge Clock) begin
      idx_mem_q  <= idx_mem_d;
      pred_mem_q <= pred_mem_d;
      alt_mem_q  <= alt_mem_d;
   end

   assign head_idx    = idx_mem_q[rd_ptr_q];
   assign head_pred   = pred_mem_q[rd_ptr_q];
   assign head_alt_pc = alt_mem_q[rd_ptr_q];
   assign count       = count_q;

endmodule

// File: rtl/branch_outcome_tracker.sv
// Branch outcome tracker.
// Records every predicted branch issued by fetch and, as execute resolves
// branches in program order, produces registered predictor updates and a
// one-cycle mispredict/redirect pulse. A mispredict discards all younger
// in-flight entries, including a fetch arriving in the same cycle.
// Ports:
//   Clock, Reset                 rising-edge clock, synchronous active-high reset
//   FetchValid/Idx/Pred/AltPC    new predicted branch from fetch
//   ResValid, ResTaken           resolution of the oldest branch
//   Full, Count                  occupancy
//   UpdEn, UpdIdx, UpdPredActual predictor update (UpdEn is a pulse)
//   Mispredict, RedirectPC       flush pulse and recovery PC
//   Overflow, Underflow          sticky protocol-error flags
module branch_outcome_tracker
   import branch_outcome_tracker_pkg::*;
#(
   parameter int DEPTH = BOT_DEPTH,
   parameter int IDX_W = BOT_IDX_W,
   parameter int PC_W  = BOT_PC_W
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     FetchValid,
   input  logic [IDX_W-1:0]         FetchIdx,
   input  logic                     FetchPred,
   input  logic [PC_W-1:0]          FetchAltPC,
   input  logic                     ResValid,
   input  logic                     ResTaken,
   output logic                     Full,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     UpdEn,
   output logic [IDX_W-1:0]         UpdIdx,
   output logic [1:0]               UpdPredActual,
   output logic                     Mispredict,
   output logic [PC_W-1:0]          RedirectPC,
   output logic                     Overflow,
   output logic                     Underflow
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [IDX_W-1:0] head_idx;
   logic             head_pred;
   logic [PC_W-1:0]  head_alt_pc;
   logic [CNT_W-1:0] count;

   logic empty, full;
   logic res_fire, res_mis, pop_en, push_en, flush_en;

   logic             upd_en_q, upd_en_d;
   logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
   pred_actual_e     upd_pa_q, upd_pa_d;
   logic             mispredict_q, mispredict_d;
   logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

   // A mispredicting resolution flushes the whole queue (head included)
   // instead of popping, and drops any same-cycle fetch as wrong-path.
   // A correct pop frees a slot, so a push while full is still accepted.
   always_comb begin
      res_fire = ResValid && !empty;
      res_mis  = res_fire && is_mispredict(head_pred, ResTaken);
      pop_en   = res_fire && !res_mis;
      flush_en = res_mis;
      push_en  = FetchValid && !res_mis && (!full || pop_en);
   end

   always_comb begin
      upd_en_d      = res_fire;
      upd_idx_d     = upd_idx_q;
      upd_pa_d      = upd_pa_q;
      mispredict_d  = res_mis;
      redirect_pc_d = redirect_pc_q;
      overflow_d    = overflow_q;
      underflow_d   = underflow_q;
      if (res_fire) begin
         upd_idx_d = head_idx;
         upd_pa_d  = pack_pred_actual(head_pred, ResTaken);
      end
      if (res_mis) begin
         redirect_pc_d = head_alt_pc;
      end
      if (FetchValid && !res_mis && full && !pop_en) begin
         overflow_d = 1'b1;
      end
      if (ResValid && empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         upd_en_q      <= 1'b0;
         upd_idx_q     <= '0;
         upd_pa_q      <= PA_CORRECT_NT;
         mispredict_q  <= 1'b0;
         redirect_pc_q <= '0;
         overflow_q    <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         upd_en_q      <= upd_en_d;
         upd_idx_q     <= upd_idx_d;
         upd_pa_q      <= upd_pa_d;
         mispredict_q  <= mispredict_d;
         redirect_pc_q <= redirect_pc_d;
         overflow_q    <= overflow_d;
         underflow_q   <= underflow_d;
      end
   end

   bot_entry_fifo #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W),
      .PC_W  (PC_W)
   ) u_fifo (
      .Clock       (Clock),
      .Reset       (Reset),
      .push_en     (push_en),
      .pop_en      (pop_en),
      .flush_en    (flush_en),
      .push_idx    (FetchIdx),
      .push_pred   (FetchPred),
      .push_alt_pc (FetchAltPC),
      .head_idx    (head_idx),
      .head_pred   (head_pred),
      .head_alt_pc (head_alt_pc),
      .count       (count)
   );

   assign Full          = full;
   assign Count         = count;
   assign UpdEn         = upd_en_q;
   assign UpdIdx        = upd_idx_q;
   assign UpdPredActual = upd_pa_q;
   assign Mispredict    = mispredict_q;
   assign RedirectPC    = redirect_pc_q;
   assign Overflow      = overflow_q;
   assign Underflow     = underflow_q;

endmodule

// File: doc/branch_outcome_tracker.md
BRANCH_OUTCOME_TRACKER -- requirements
Module: branch_outcome_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight branch entries (power of two, 2..16).
REQ-002 SHALL have parameter IDX_W, default 4, predictor buffer index width (16 locations).
REQ-003 SHALL have parameter PC_W, default 16, PC width.
REQ-004 Clock  in  1  rising-edge clock.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 FetchValid  in  1  fetch issues a predicted branch this cycle.
REQ-007 FetchIdx  in  IDX_W  predictor index used at fetch (low PC bits).
REQ-008 FetchPred  in  1  prediction used at fetch (1 = taken).
REQ-009 FetchAltPC  in  PC_W  PC of the path not chosen at fetch.
REQ-010 ResValid  in  1  execute resolves the oldest in-flight branch this cycle.
REQ-011 ResTaken  in  1  actual outcome (1 = taken).
REQ-012 Full  out  1  no free entry.
REQ-013 Count  out  clog2(DEPTH)+1  occupied entries.
REQ-014 UpdEn  out  1  predictor update strobe.
REQ-015 UpdIdx  out  IDX_W  predictor location to update.
REQ-016 UpdPredActual  out  2  {predicted, actual}.
REQ-017 Mispredict  out  1  one-cycle flush/redirect pulse.
REQ-018 RedirectPC  out  PC_W  recovery PC, valid while Mispredict = 1.
REQ-019 Overflow, Underflow  out  1 each  sticky protocol-error flags.

Function
REQ-020 SHALL store {FetchIdx, FetchPred, FetchAltPC} in program order at the tail when FetchValid = 1 and the entry is accepted.
REQ-021 Resolution SHALL always apply to the head entry; each ResValid on a non-empty queue pops exactly one entry.
REQ-022 SHALL register all update outputs, one cycle after ResValid: UpdEn = 1, UpdIdx = head idx, UpdPredActual = {head pred, ResTaken}.
REQ-023 UpdEn, Mispredict SHALL be single-cycle pulses; UpdIdx, UpdPredActual, RedirectPC hold their last values otherwise.
REQ-024 On resolution with head pred != ResTaken, SHALL assert Mispredict with RedirectPC = head AltPC in the same cycle as UpdEn.
REQ-025 On a mispredicting resolution, SHALL discard all younger entries; Count = 0 next cycle.
REQ-026 On a mispredicting resolution, a FetchValid push in the same cycle SHALL be dropped (wrong path), without setting Overflow.
REQ-027 Simultaneous push and correct-prediction pop SHALL both take effect; Count is unchanged; this also applies when Full = 1.
REQ-028 A push when Full = 1 without a same-cycle pop SHALL be dropped and set Overflow.
REQ-029 ResValid when Count = 0 SHALL be ignored (no UpdEn) and set Underflow.
REQ-030 Pointers SHALL wrap modulo DEPTH; Full = (Count == DEPTH), combinational from registered Count.
REQ-031 Entries are unchanged between push and pop; the block adds no bypass of fetch data to the update outputs.

Reset
REQ-032 On Reset, SHALL clear Count, pointers, UpdEn, Mispredict, Overflow, Underflow, UpdPredActual, UpdIdx, RedirectPC (all 0); Full = 0.
REQ-033 Reset SHALL override any same-cycle push or resolution; a pending update pulse is cancelled.
REQ-034 Entry storage contents need not be reset.

Structure
REQ-035 A shared package SHALL hold DEPTH/IDX_W/PC_W defaults and the PredActual encodings (00/11 correct, 01 missed-taken, 10 missed-not-taken).
REQ-036 The entry storage plus pointers SHALL be one sub-module, bot_entry_fifo; the top holds the resolve/flush control and output registers.

Verification
REQ-037 Push idx 3 pred 1 alt 0x0040; resolve taken -> next cycle UpdEn = 1, UpdIdx = 3, UpdPredActual = 11, Mispredict = 0, Count = 0.
REQ-038 Push idx 5 pred 0 alt 0x0100, push idx 6 pred 1; resolve taken -> UpdPredActual = 01, Mispredict = 1, RedirectPC = 0x0100, Count = 0, idx 6 is never updated.
REQ-039 Fill 4 entries (Full = 1); push a 5th -> dropped, Overflow = 1; push plus correct pop in one cycle -> Count stays 4, Overflow not newly set.
REQ-040 Resolve with Count = 0 -> no UpdEn, Underflow = 1, stays 1 until Reset.
REQ-041 Mispredict resolution and FetchValid in the same cycle -> Count = 0, pushed entry absent, Overflow = 0.
REQ-042 Assert Reset in the ResValid cycle with 2 entries -> next cycle UpdEn = 0, Count = 0, Full = 0, all flags 0.
